// File: rtl/ftdi_pkg.sv
// rtl/ftdi_pkg.sv - shared state encoding and timing constants for the FT2232H 245-FIFO bridge
package ftdi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_LOW   = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_LOW   = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_RECOVER  = 3'd5
    } ftdi_state_e;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } ftdi_dir_e;

    localparam int FTDI_SYNC_DEPTH   = 2;
    localparam int FTDI_RD_PULSE_DEF = 3;
    localparam int FTDI_WR_PULSE_DEF = 3;
    localparam int FTDI_RECOVERY_DEF = 4;
    localparam int FTDI_CNT_W        = 8;

    // The device owns the bus for the whole setup/strobe/hold window of a write.
    function automatic logic ftdi_drives_bus(input ftdi_state_e s);
        return (s == ST_WR_SETUP) || (s == ST_WR_LOW) || (s == ST_WR_HOLD);
    endfunction

endpackage

// File: rtl/ftdi_byte_fifo.sv
// rtl/ftdi_byte_fifo.sv - synchronous show-ahead byte FIFO with full/empty flags
module ftdi_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic [7:0] rd_data,
    input  logic       rd_en,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_wr;
    logic        do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ftdi_async_fifo_if.sv
// rtl/ftdi_async_fifo_if.sv - FT2232H async 245-FIFO strobe engine with rx/tx byte streams
// Define FTDI_TX_FIFO_EN to buffer the transmit stream in ftdi_byte_fifo.
module ftdi_async_fifo_if
    import ftdi_pkg::*;
#(
    parameter int RD_PULSE_CYCLES = FTDI_RD_PULSE_DEF,
    parameter int WR_PULSE_CYCLES = FTDI_WR_PULSE_DEF,
    parameter int RECOVERY_CYCLES = FTDI_RECOVERY_DEF,
    parameter int TX_FIFO_DEPTH   = 16
) (
    input  logic       in_clk,
    input  logic       in_reset,
    input  logic       in_ftdi_rxf_n,
    input  logic       in_ftdi_txe_n,
    output logic       out_ftdi_rd_n,
    output logic       out_ftdi_wr_n,
    inout  wire  [7:0] io_ftdi_data,
    output logic [7:0] out_rx_data,
    output logic       out_rx_valid,
    input  logic       in_rx_ready,
    input  logic [7:0] in_tx_data,
    input  logic       in_tx_valid,
    output logic       out_tx_ready
);

    localparam logic [FTDI_CNT_W-1:0] RD_LOAD  = FTDI_CNT_W'(RD_PULSE_CYCLES - 1);
    localparam logic [FTDI_CNT_W-1:0] WR_LOAD  = FTDI_CNT_W'(WR_PULSE_CYCLES - 1);
    localparam logic [FTDI_CNT_W-1:0] REC_LOAD = FTDI_CNT_W'(RECOVERY_CYCLES - 1);

    if (RECOVERY_CYCLES < FTDI_SYNC_DEPTH + 2) begin : g_bad_recovery
        $error("RECOVERY_CYCLES too short for the flag synchronisers");
    end
    if (TX_FIFO_DEPTH < 2 || (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("TX_FIFO_DEPTH must be a power of two");
    end

    ftdi_state_e                state_q, state_d;
    logic [FTDI_CNT_W-1:0]      cnt_q, cnt_d;
    ftdi_dir_e                  last_q, last_d;
    logic [FTDI_SYNC_DEPTH-1:0] rxf_sh_q, rxf_sh_d;
    logic [FTDI_SYNC_DEPTH-1:0] txe_sh_q, txe_sh_d;
    logic                       rd_n_q, rd_n_d;
    logic                       wr_n_q, wr_n_d;
    logic                       oe_q, oe_d;
    logic [7:0]                 rx_data_q, rx_data_d;
    logic                       rx_valid_q, rx_valid_d;
    logic [7:0]                 tx_byte_q, tx_byte_d;

    logic       rxf_sync, txe_sync;
    logic       rd_elig, wr_elig;
    logic       start_rd, start_wr;
    logic       tx_pending;
    logic [7:0] tx_head;
    logic       capture;

    assign rxf_sync = rxf_sh_q[FTDI_SYNC_DEPTH-1];
    assign txe_sync = txe_sh_q[FTDI_SYNC_DEPTH-1];
    assign rd_elig  = !rxf_sync && !rx_valid_q;
    assign wr_elig  = !txe_sync && tx_pending;
    // When both sides want the bus, serve the direction not served last time.
    assign start_rd = (state_q == ST_IDLE) && rd_elig && (!wr_elig || last_q == DIR_WR);
    assign start_wr = (state_q == ST_IDLE) && wr_elig && !start_rd;
    assign capture  = (state_q == ST_RD_LOW) && (cnt_q == '0);

`ifdef FTDI_TX_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;

    ftdi_byte_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk     (in_clk),
        .reset   (in_reset),
        .wr_data (in_tx_data),
        .wr_en   (in_tx_valid),
        .full    (fifo_full),
        .rd_data (fifo_head),
        .rd_en   (start_wr),
        .empty   (fifo_empty)
    );

    assign tx_pending   = !fifo_empty;
    assign tx_head      = fifo_head;
    assign out_tx_ready = !fifo_full && !in_reset;
`else
    assign tx_pending   = in_tx_valid;
    assign tx_head      = in_tx_data;
    assign out_tx_ready = (state_q == ST_IDLE) && !txe_sync && !(rd_elig && last_q == DIR_WR);
`endif

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_q     <= DIR_WR;
            rxf_sh_q   <= '1;
            txe_sh_q   <= '1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            oe_q       <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            rxf_sh_q   <= rxf_sh_d;
            txe_sh_q   <= txe_sh_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rd) begin
                    state_d = ST_RD_LOW;
                    cnt_d   = RD_LOAD;
                    last_d  = DIR_RD;
                end else if (start_wr) begin
                    state_d = ST_WR_SETUP;
                    last_d  = DIR_WR;
                end
            end
            ST_RD_LOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_RECOVER;
                    cnt_d   = REC_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_LOW;
                cnt_d   = WR_LOAD;
            end
            ST_WR_LOW: begin
                if (cnt_q == '0) state_d = ST_WR_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_WR_HOLD: begin
                state_d = ST_RECOVER;
                cnt_d   = REC_LOAD;
            end
            ST_RECOVER: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes and OE are decoded from the next state so the pins come straight off flops.
    always_comb begin
        rxf_sh_d   = {rxf_sh_q[FTDI_SYNC_DEPTH-2:0], in_ftdi_rxf_n};
        txe_sh_d   = {txe_sh_q[FTDI_SYNC_DEPTH-2:0], in_ftdi_txe_n};
        rd_n_d     = (state_d != ST_RD_LOW);
        wr_n_d     = (state_d != ST_WR_LOW);
        oe_d       = ftdi_drives_bus(state_d);
        rx_data_d  = capture ? io_ftdi_data : rx_data_q;
        rx_valid_d = capture || (rx_valid_q && !in_rx_ready);
        tx_byte_d  = start_wr ? tx_head : tx_byte_q;
    end

    assign out_ftdi_rd_n = rd_n_q;
    assign out_ftdi_wr_n = wr_n_q;
    assign io_ftdi_data  = oe_q ? tx_byte_q : 8'hzz;
    assign out_rx_data   = rx_data_q;
    assign out_rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_ftdi_async_fifo_if.sv
// tb/tb_ftdi_async_fifo_if.sv - bench for ftdi_async_fifo_if with FT2232H pin model and byte scoreboards
module tb_ftdi_async_fifo_if;

    localparam int RD_W = 3;
    localparam int WR_W = 3;

    logic       clk = 1'b0;
    logic       reset, rxf_n, txe_n, rx_ready, tx_valid;
    logic [7:0] tx_data;
    logic [7:0] host_byte;
    wire        rd_n, wr_n, rx_valid, tx_ready;
    wire  [7:0] rx_data;
    wire  [7:0] bus;

    always #5 clk = ~clk;

    assign bus = rd_n ? 8'hzz : host_byte;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus[g]);
    end

    ftdi_async_fifo_if dut (
        .in_clk        (clk),
        .in_reset      (reset),
        .in_ftdi_rxf_n (rxf_n),
        .in_ftdi_txe_n (txe_n),
        .out_ftdi_rd_n (rd_n),
        .out_ftdi_wr_n (wr_n),
        .io_ftdi_data  (bus),
        .out_rx_data   (rx_data),
        .out_rx_valid  (rx_valid),
        .in_rx_ready   (rx_ready),
        .in_tx_data    (tx_data),
        .in_tx_valid   (tx_valid),
        .out_tx_ready  (tx_ready)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] host_q[$];
    logic [7:0] rx_exp[$];
    logic [7:0] wr_exp[$];
    logic [7:0] ev_log[$];
    int         rd_events = 0, wr_events = 0, rd_low = 0, wr_low = 0;
    logic [7:0] prev_bus = 8'hFF;

    // Host-side pin model and scoreboard, evaluated on the falling edge.
    task automatic monitor_step();
        checks++;
        if (!rd_n && !wr_n) begin
            errors++; $display("FAIL strobes_overlap: rd_n=%b wr_n=%b required not both low", rd_n, wr_n);
        end
        if (!rd_n) begin
            rd_low++;
            checks++;
            if (bus !== host_byte) begin
                errors++; $display("FAIL bus_during_read: got %h required %h", bus, host_byte);
            end
            if (rd_low == 1 && host_q.size() == 0) begin
                checks++; errors++; $display("FAIL unexpected_read: got rd_n fall required none");
            end
        end else if (rd_low != 0) begin
            checks += 2;
            if (rd_low != RD_W) begin
                errors++; $display("FAIL rd_width: got %0d required %0d", rd_low, RD_W);
            end
            if (rx_valid !== 1'b1) begin
                errors++; $display("FAIL rx_valid_at_rise: got %b required 1", rx_valid);
            end
            rd_events++;
            ev_log.push_back("R");
            if (host_q.size() != 0) void'(host_q.pop_front());
            rd_low = 0;
        end
        if (!wr_n) begin
            wr_low++;
            checks++;
            if (wr_exp.size() == 0) begin
                errors++; $display("FAIL unexpected_write: got wr_n low with bus %h required none", bus);
            end else begin
                if (bus !== wr_exp[0]) begin
                    errors++; $display("FAIL wr_data: got %h required %h", bus, wr_exp[0]);
                end
                if (wr_low == 1) begin
                    checks++;
                    if (prev_bus !== wr_exp[0]) begin
                        errors++; $display("FAIL wr_setup: got %h required %h", prev_bus, wr_exp[0]);
                    end
                end
            end
        end else if (wr_low != 0) begin
            checks++;
            if (wr_low != WR_W) begin
                errors++; $display("FAIL wr_width: got %0d required %0d", wr_low, WR_W);
            end
            if (wr_exp.size() != 0) begin
                checks++;
                if (bus !== wr_exp[0]) begin
                    errors++; $display("FAIL wr_hold: got %h required %h", bus, wr_exp[0]);
                end
                void'(wr_exp.pop_front());
            end
            wr_events++;
            ev_log.push_back("W");
            wr_low = 0;
        end
        if (rx_valid && rx_ready) begin
            checks++;
            if (rx_exp.size() == 0) begin
                errors++; $display("FAIL rx_unexpected: got %h required nothing", rx_data);
            end else if (rx_data !== rx_exp[0]) begin
                errors++; $display("FAIL rx_data: got %h required %h", rx_data, rx_exp[0]);
                void'(rx_exp.pop_front());
            end else begin
                void'(rx_exp.pop_front());
            end
        end
        prev_bus  = bus;
        host_byte = (host_q.size() != 0) ? host_q[0] : 8'h00;
        rxf_n     = (host_q.size() == 0);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (!tx_ready) begin
            errors++; $display("FAIL tx_accept_timeout: got tx_ready=0 required 1 for byte %h", b);
        end else begin
            wr_exp.push_back(b);
            tick();
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        int cyc = 0;
        reset    = 1'b1;
        rx_ready = 1'b1;
        host_q.push_back(8'h5A);
        rx_exp.push_back(8'h5A);
        repeat (3) begin
            tick();
            checks++;
            if ({rd_n, wr_n, rx_valid, tx_ready, rx_data, bus} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF}) begin
                errors++;
                $display("FAIL reset_state: got rd_n=%b wr_n=%b rx_valid=%b tx_ready=%b rx_data=%h bus=%h required 1 1 0 0 00 ff",
                         rd_n, wr_n, rx_valid, tx_ready, rx_data, bus);
            end
        end
        reset = 1'b0;
        while (cyc < 10) begin
            tick();
            cyc++;
            if (!rd_n) break;
        end
        checks++;
        if (cyc != 3 || rd_n !== 1'b0) begin
            errors++; $display("FAIL reset_to_rd: got %0d cycles (rd_n=%b) required 3", cyc, rd_n);
        end
    endtask

    task automatic test_single_read();
        int low = 1;
        while (low < 20) begin
            tick();
            if (rd_n) break;
            low++;
        end
        checks++;
        if (low != RD_W) begin
            errors++; $display("FAIL single_rd_width: got %0d required %0d", low, RD_W);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            errors++; $display("FAIL single_rd_data: got valid=%b data=%h required 1 5a", rx_valid, rx_data);
        end
        tick();
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL single_rd_valid_len: got %b required 0", rx_valid);
        end
        repeat (8) tick();
    endtask

    task automatic test_backpressure();
        int base = rd_events;
        int n = 0;
        rx_ready = 1'b0;
        host_q.push_back(8'h11); rx_exp.push_back(8'h11);
        host_q.push_back(8'h22); rx_exp.push_back(8'h22);
        repeat (30) tick();
        checks++;
        if (rd_events - base != 1 || rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            errors++; $display("FAIL bp_hold: got pulses=%0d valid=%b data=%h required 1 1 11", rd_events - base, rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        while (rd_events - base < 2 && n < 40) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (rd_events - base != 2 || rx_data !== 8'h22 || rx_valid !== 1'b0 || rx_exp.size() != 0) begin
            errors++; $display("FAIL bp_release: got pulses=%0d data=%h valid=%b pending=%0d required 2 22 0 0",
                               rd_events - base, rx_data, rx_valid, rx_exp.size());
        end
    endtask

    task automatic test_write();
        int base = wr_events;
        int n = 0;
        txe_n = 1'b0;
        send_byte(8'hAA);
        send_byte(8'h55);
        while (wr_events - base < 2 && n < 60) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (wr_events - base != 2 || wr_exp.size() != 0) begin
            errors++; $display("FAIL write_count: got %0d pulses, %0d pending required 2, 0", wr_events - base, wr_exp.size());
        end
`ifndef FTDI_TX_FIFO_EN
        begin
            int seen = 0;
            txe_n = 1'b1;
            repeat (4) tick();
            tx_data  = 8'h77;
            tx_valid = 1'b1;
            repeat (20) begin
                tick();
                if (tx_ready) seen++;
            end
            tx_valid = 1'b0;
            checks++;
            if (seen != 0 || wr_events - base != 2) begin
                errors++; $display("FAIL txe_blocked: got ready_cycles=%0d pulses=%0d required 0 2", seen, wr_events - base);
            end
        end
`endif
    endtask

`ifdef FTDI_TX_FIFO_EN
    task automatic test_fifo();
        int base;
        int n = 0;
        txe_n = 1'b1;
        repeat (4) tick();
        base = wr_events;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        checks++;
        if (tx_ready !== 1'b0 || wr_events != base) begin
            errors++; $display("FAIL fifo_full: got tx_ready=%b pulses=%0d required 0 0", tx_ready, wr_events - base);
        end
        txe_n = 1'b0;
        while (wr_events - base < 16 && n < 250) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (wr_events - base != 16 || wr_exp.size() != 0) begin
            errors++; $display("FAIL fifo_drain: got %0d pulses, %0d pending required 16, 0", wr_events - base, wr_exp.size());
        end
    endtask
`endif

    task automatic test_contention();
        int  base_r;
        int  lb;
        int  n = 0;
        logic ok;
        rx_ready = 1'b1;
        txe_n    = 1'b1;
        repeat (4) tick();
        base_r = rd_events;
        lb     = ev_log.size();
        for (int k = 0; k < 6; k++) begin
            host_q.push_back(8'h30 + 8'(k));
            rx_exp.push_back(8'h30 + 8'(k));
        end
        txe_n    = 1'b0;
        tx_data  = 8'hEF;
        tx_valid = 1'b1;
        while (rd_events - base_r < 6 && n < 300) begin
            if (tx_ready) wr_exp.push_back(8'hEF);
            tick();
            n++;
        end
        tx_valid = 1'b0;
        checks++;
        if (rd_events - base_r != 6) begin
            errors++; $display("FAIL contention_reads: got %0d required 6", rd_events - base_r);
        end
        n = 0;
        while (wr_exp.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        repeat (5) tick();
        checks++;
        if (wr_exp.size() != 0 || rx_exp.size() != 0) begin
            errors++; $display("FAIL contention_drain: got wr=%0d rx=%0d pending required 0 0", wr_exp.size(), rx_exp.size());
        end
        ok = (ev_log.size() - lb >= 11) && (ev_log[lb] == "R");
        for (int i = 1; i < 11 && ok; i++) begin
            if (ev_log[lb + i] == ev_log[lb + i - 1]) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL alternation: got %0d events starting %s required R/W alternation from R",
                               ev_log.size() - lb, (ev_log.size() > lb) ? string'(ev_log[lb]) : "none");
        end
    endtask

    initial begin
        reset     = 1'b1;
        rxf_n     = 1'b1;
        txe_n     = 1'b1;
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        host_byte = 8'h00;
        test_reset();
        test_single_read();
        test_backpressure();
        test_write();
`ifdef FTDI_TX_FIFO_EN
        test_fifo();
`endif
        test_contention();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
